// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory bridge and its load aligner.
package dmem_pkg;

  // Access state of the MEM-stage bridge.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } state_t;

  // Funct3 encodings for access size and signedness.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Halfwords need an even address, words (and unknown sizes) need addr[1:0] == 0.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    logic mis;
    case (funct3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Extracts the addressed byte/halfword from a read word and sign/zero extends it.
module dmem_load_align (
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  import dmem_pkg::*;

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select by byte offset, then extension by access type.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    data   = 32'h0000_0000;
    case (off)
      2'b00:   byte_s = word[7:0];
      2'b01:   byte_s = word[15:8];
      2'b10:   byte_s = word[23:16];
      2'b11:   byte_s = word[31:24];
      default: byte_s = 8'h00;
    endcase
    if (off[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
    case (funct3)
      F3_B:    data = {{24{byte_s[7]}}, byte_s};
      F3_H:    data = {{16{half_s[15]}}, half_s};
      F3_W:    data = word;
      F3_BU:   data = {24'h00_0000, byte_s};
      F3_HU:   data = {16'h0000, half_s};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// MEM-stage data-memory bridge: stalls the pipeline while one load/store runs on
// a valid/ready request bus, steers store lanes and extends load data.
module dmem_bridge #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemWriteM,
  input  logic          MemReadM,
  input  logic [2:0]    Funct3M,
  input  logic [AW-1:0] ALUResultM,
  input  logic [DW-1:0] WriteDataM,
  output logic [DW-1:0] ReadDataM,
  output logic          StallM,
  output logic          MisalignM,
  output logic          bus_req_valid,
  input  logic          bus_req_ready,
  output logic          bus_req_we,
  output logic [AW-1:0] bus_req_addr,
  output logic [DW-1:0] bus_req_wdata,
  output logic [3:0]    bus_req_wstrb,
  input  logic          bus_rsp_valid,
  input  logic [DW-1:0] bus_rsp_rdata
);
  import dmem_pkg::*;

  state_t        state_r;
  state_t        state_s;
  logic          access_s;
  logic          misaligned_s;
  logic          start_s;
  logic          capture_s;
  logic [DW-1:0] wdata_s;
  logic [3:0]    wstrb_s;
  logic          we_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic [3:0]    wstrb_r;
  logic [2:0]    funct3_r;
  logic [1:0]    off_r;
  logic [DW-1:0] rdata_r;

  assign access_s     = MemWriteM | MemReadM;
  assign misaligned_s = access_s && is_misaligned(Funct3M, ALUResultM[1:0]);
  assign start_s      = (state_r == IDLE) && access_s && !misaligned_s;
  // Read data is captured either with the accept (skipping WAIT) or later in WAIT.
  assign capture_s    = ((state_r == REQ) && bus_req_ready && !we_r && bus_rsp_valid) ||
                        ((state_r == WAIT) && bus_rsp_valid);

  // Stall drops in DONE so MEM/WB can capture ReadDataM; misaligned accesses never stall.
  assign StallM        = access_s && (state_r != DONE) && !misaligned_s;
  assign MisalignM     = (state_r == IDLE) && misaligned_s;
  assign bus_req_valid = (state_r == REQ);
  assign bus_req_we    = we_r;
  assign bus_req_addr  = addr_r;
  assign bus_req_wdata = wdata_r;
  assign bus_req_wstrb = wstrb_r;

  // Store steering: replicate the low lanes across the word and strobe the addressed bytes.
  always_comb begin
    wdata_s = WriteDataM;
    wstrb_s = 4'b1111;
    case (Funct3M[1:0])
      2'b00: begin
        wdata_s = {4{WriteDataM[7:0]}};
        wstrb_s = 4'b0001 << ALUResultM[1:0];
      end
      2'b01: begin
        wdata_s = {2{WriteDataM[15:0]}};
        if (ALUResultM[1]) begin
          wstrb_s = 4'b1100;
        end else begin
          wstrb_s = 4'b0011;
        end
      end
      default: begin
        wdata_s = WriteDataM;
        wstrb_s = 4'b1111;
      end
    endcase
  end

  // Next-state logic for the access sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (bus_req_ready) begin
          if (we_r || bus_rsp_valid) begin
            state_s = DONE;
          end else begin
            state_s = WAIT;
          end
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        if (bus_rsp_valid) begin
          state_s = DONE;
        end else begin
          state_s = WAIT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request fields latched at start and held until accepted; read word captured on response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_r     <= 1'b0;
      addr_r   <= '0;
      wdata_r  <= '0;
      wstrb_r  <= 4'b0000;
      funct3_r <= 3'b000;
      off_r    <= 2'b00;
      rdata_r  <= '0;
    end else begin
      if (start_s) begin
        we_r     <= MemWriteM;
        addr_r   <= {ALUResultM[AW-1:2], 2'b00};
        wdata_r  <= wdata_s;
        wstrb_r  <= wstrb_s;
        funct3_r <= Funct3M;
        off_r    <= ALUResultM[1:0];
      end
      if (capture_s) begin
        rdata_r <= bus_rsp_rdata;
      end
    end
  end

  dmem_load_align u_load_align (
    .word   (rdata_r),
    .off    (off_r),
    .funct3 (funct3_r),
    .data   (ReadDataM)
  );

endmodule
